present_core: RTL and testbench
===============================

Name: present_core

Overview:
- Parametrised iterative PRESENT block-cipher engine, one round per cycle.
- Supports 80- or 128-bit keys (elaboration-time) and run-time encrypt/decrypt selection.
- Handshake is start/busy/done.
- Next-generation crypto core behind the chip's register wrapper, alongside the existing encrypt-only 80-bit engine.

Parameters:
- KEY_WIDTH, 80, key size; legal values 80 or 128; any other value is an elaboration error.
- NUM_ROUNDS, 31, number of full rounds. Test builds may reduce it (min 1, max 31).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- decrypt  input  1  0 = encrypt, 1 = decrypt; sampled with start.
- din  input  64  plaintext or ciphertext; sampled with start.
- key  input  KEY_WIDTH  user key; sampled with start.
- dout  output  64  result; held until the next accepted start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse, coincident with dout update.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; dout=0, busy=0, done=0; data, key and round registers cleared. Reset mid-operation aborts with no done.
- Round key K_i = top 64 bits of the key register.
- Key update, 80-bit: rotate left 61; S-box on [79:76]; [19:15] ^= i.
- Key update, 128-bit: rotate left 61; S-box on [127:124] and [123:120]; [66:62] ^= i.
- Inverse key update (both widths): undo the xor, apply inverse S-box(es), rotate right 61.
- FSM states: IDLE, KEYEXP, ROUND, FINAL.
- IDLE + start=1:
  - Capture din, key and mode; set busy.
  - Encrypt: go to ROUND with i=1.
  - Decrypt: go to KEYEXP with i=1.
- KEYEXP (decrypt only):
  - Each cycle: key <= update(key, i); i++.
  - After NUM_ROUNDS cycles the key register holds K_(NUM_ROUNDS+1); go to ROUND.
- ROUND, encrypt:
  - state <= P(S(state ^ K_i)); key <= update(key, i); i++.
  - After NUM_ROUNDS cycles go to FINAL.
- ROUND, decrypt:
  - i counts NUM_ROUNDS+1 down to 2.
  - state <= S^-1(P^-1(state ^ K_i)); key <= invupdate(key, i-1).
- FINAL: dout <= state ^ current round key; done=1 for one cycle; busy=0; return to IDLE.
- Latency, start edge to done high:
  - Encrypt: NUM_ROUNDS+1 cycles (32 at default).
  - Decrypt: 2*NUM_ROUNDS+1 cycles (63 at default).
- Back-to-back: start is accepted in the cycle after done (IDLE). start while busy is ignored, not queued. done and a new acceptance never share a cycle.
- Inputs may change freely after acceptance; no effect until the next start.
- Round counter is 5 bits; it never wraps within legal NUM_ROUNDS.

Optional Feature:
- Macro: PRESENT_KEY_CACHE_EN.
- When defined:
  - The core stores the last user key plus its final round-key state (KEY_WIDTH bits each) and a valid flag.
  - The cache is updated at the end of any KEYEXP.
  - A decrypt start whose key equals the cached key skips KEYEXP, loads the cached final key and enters ROUND directly (latency NUM_ROUNDS+1).
  - A finished encrypt also fills the cache (the final key state is free there).
  - Reset clears the valid flag.
- When undefined:
  - No cache storage.
  - Decrypt always runs KEYEXP.

Test Plan:
- KEY_WIDTH=80, encrypt, key=0, din=0 -> dout=5579C1387B228445, done exactly 32 cycles after start, busy high 31 cycles.
- KEY_WIDTH=80, encrypt, key=all-ones, din=0 -> E72C46C0F5945049.
- KEY_WIDTH=80, decrypt, key=0, din=A112FFC72F68417B -> dout=FFFFFFFFFFFFFFFF after 63 cycles.
- KEY_WIDTH=128, encrypt then decrypt, key=0, din=0:
  - Encrypt -> 96DB702A2E6900AF.
  - Decrypt round-trips to 0.
  - With PRESENT_KEY_CACHE_EN, the second operation completes in 32 cycles.
- start pulsed while busy, then rst_n low at round 10 -> no done, dout=0, FSM IDLE. A fresh start afterwards produces the correct 5579C1387B228445.
- Back-to-back random vectors with start raised the cycle after done -> every result matches the golden model, with no lost or duplicated done pulses.

Source files
------------

// File: rtl/present_core_if.sv
// Start/busy/done handshake and data bus of the PRESENT engine.
interface present_core_if #(
    parameter int KEY_WIDTH = 80
);
    logic                 start;
    logic                 decrypt;
    logic [63:0]          din;
    logic [KEY_WIDTH-1:0] key;
    logic [63:0]          dout;
    logic                 busy;
    logic                 done;

    modport master (output start, decrypt, din, key, input dout, busy, done);
    modport slave  (input start, decrypt, din, key, output dout, busy, done);
endinterface

// File: rtl/present_core.sv
// Iterative PRESENT-80/128 encrypt/decrypt engine, one round per clock.
// PRESENT_KEY_CACHE_EN adds a one-entry cache of the final key-schedule state.
module present_core #(
    parameter int KEY_WIDTH  = 80,
    parameter int NUM_ROUNDS = 31
) (
    input  logic          clk,
    input  logic          rst_n,
    present_core_if.slave bus
);

    if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : g_bad_key_width
        $error("present_core: KEY_WIDTH must be 80 or 128");
    end
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 31) begin : g_bad_rounds
        $error("present_core: NUM_ROUNDS must be in 1..31");
    end

    localparam int         XOR_LSB = (KEY_WIDTH == 128) ? 62 : 15;
    localparam logic [4:0] NR5     = 5'(NUM_ROUNDS);

    typedef enum logic [1:0] {S_IDLE, S_KEYEXP, S_ROUND, S_FINAL} state_e;

    state_e               state_q, state_d;
    logic [63:0]          data_q, data_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic [4:0]           rnd_q, rnd_d;
    logic                 dec_q, dec_d;
    logic [63:0]          dout_q, dout_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

`ifdef PRESENT_KEY_CACHE_EN
    logic [KEY_WIDTH-1:0] ck_key_q, ck_key_d;
    logic [KEY_WIDTH-1:0] ck_fin_q, ck_fin_d;
    logic                 ck_vld_q, ck_vld_d;
`endif

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        case (x)
            4'h0: sbox4 = 4'hC;  4'h1: sbox4 = 4'h5;  4'h2: sbox4 = 4'h6;  4'h3: sbox4 = 4'hB;
            4'h4: sbox4 = 4'h9;  4'h5: sbox4 = 4'h0;  4'h6: sbox4 = 4'hA;  4'h7: sbox4 = 4'hD;
            4'h8: sbox4 = 4'h3;  4'h9: sbox4 = 4'hE;  4'hA: sbox4 = 4'hF;  4'hB: sbox4 = 4'h8;
            4'hC: sbox4 = 4'h4;  4'hD: sbox4 = 4'h7;  4'hE: sbox4 = 4'h1;  default: sbox4 = 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] isbox4(input logic [3:0] x);
        case (x)
            4'h0: isbox4 = 4'h5;  4'h1: isbox4 = 4'hE;  4'h2: isbox4 = 4'hF;  4'h3: isbox4 = 4'h8;
            4'h4: isbox4 = 4'hC;  4'h5: isbox4 = 4'h1;  4'h6: isbox4 = 4'h2;  4'h7: isbox4 = 4'hD;
            4'h8: isbox4 = 4'hB;  4'h9: isbox4 = 4'h4;  4'hA: isbox4 = 4'h6;  4'hB: isbox4 = 4'h3;
            4'hC: isbox4 = 4'h0;  4'hD: isbox4 = 4'h7;  4'hE: isbox4 = 4'h9;  default: isbox4 = 4'hA;
        endcase
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = sbox4(x[4*n +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] isbox_layer(input logic [63:0] x);
        logic [63:0] y;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = isbox4(x[4*n +: 4]);
        return y;
    endfunction

    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y[63] = x[63];
        for (int j = 0; j < 63; j++) y[(16*j) % 63] = x[j];
        return y;
    endfunction

    function automatic logic [63:0] ip_layer(input logic [63:0] x);
        logic [63:0] y;
        y[63] = x[63];
        for (int j = 0; j < 63; j++) y[j] = x[(16*j) % 63];
        return y;
    endfunction

    function automatic logic [KEY_WIDTH-1:0] key_upd(input logic [KEY_WIDTH-1:0] k,
                                                     input logic [4:0] i);
        logic [KEY_WIDTH-1:0] r;
        r = {k[KEY_WIDTH-62:0], k[KEY_WIDTH-1:KEY_WIDTH-61]};
        r[KEY_WIDTH-1 -: 4] = sbox4(r[KEY_WIDTH-1 -: 4]);
        if (KEY_WIDTH == 128) r[KEY_WIDTH-5 -: 4] = sbox4(r[KEY_WIDTH-5 -: 4]);
        r[XOR_LSB +: 5] = r[XOR_LSB +: 5] ^ i;
        return r;
    endfunction

    function automatic logic [KEY_WIDTH-1:0] key_inv(input logic [KEY_WIDTH-1:0] k,
                                                     input logic [4:0] i);
        logic [KEY_WIDTH-1:0] r;
        r = k;
        r[XOR_LSB +: 5] = r[XOR_LSB +: 5] ^ i;
        r[KEY_WIDTH-1 -: 4] = isbox4(r[KEY_WIDTH-1 -: 4]);
        if (KEY_WIDTH == 128) r[KEY_WIDTH-5 -: 4] = isbox4(r[KEY_WIDTH-5 -: 4]);
        return {r[60:0], r[KEY_WIDTH-1:61]};
    endfunction

    // In decrypt ROUND the counter holds i-1 (NUM_ROUNDS..1) so it fits 5 bits.
    always_comb begin
        logic [63:0] rk;
        rk       = key_q[KEY_WIDTH-1 -: 64];
        state_d  = state_q;
        data_d   = data_q;
        key_d    = key_q;
        rnd_d    = rnd_q;
        dec_d    = dec_q;
        dout_d   = dout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef PRESENT_KEY_CACHE_EN
        ck_key_d = ck_key_q;
        ck_fin_d = ck_fin_q;
        ck_vld_d = ck_vld_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start && !done_q) begin
                    data_d = bus.din;
                    key_d  = bus.key;
                    dec_d  = bus.decrypt;
                    busy_d = 1'b1;
                    rnd_d  = 5'd1;
`ifdef PRESENT_KEY_CACHE_EN
                    if (bus.decrypt && ck_vld_q && ck_key_q == bus.key) begin
                        key_d   = ck_fin_q;
                        rnd_d   = NR5;
                        state_d = S_ROUND;
                    end else begin
                        ck_key_d = bus.key;
                        ck_vld_d = 1'b0;
                        state_d  = bus.decrypt ? S_KEYEXP : S_ROUND;
                    end
`else
                    state_d = bus.decrypt ? S_KEYEXP : S_ROUND;
`endif
                end
            end
            S_KEYEXP: begin
                key_d = key_upd(key_q, rnd_q);
                if (rnd_q == NR5) begin
                    state_d = S_ROUND;
`ifdef PRESENT_KEY_CACHE_EN
                    ck_fin_d = key_upd(key_q, rnd_q);
                    ck_vld_d = 1'b1;
`endif
                end else begin
                    rnd_d = rnd_q + 5'd1;
                end
            end
            S_ROUND: begin
                if (!dec_q) begin
                    data_d = p_layer(sbox_layer(data_q ^ rk));
                    key_d  = key_upd(key_q, rnd_q);
                    if (rnd_q == NR5) begin
                        state_d = S_FINAL;
                        busy_d  = 1'b0;
                    end else begin
                        rnd_d = rnd_q + 5'd1;
                    end
                end else begin
                    data_d = isbox_layer(ip_layer(data_q ^ rk));
                    key_d  = key_inv(key_q, rnd_q);
                    if (rnd_q == 5'd1) begin
                        state_d = S_FINAL;
                        busy_d  = 1'b0;
                    end else begin
                        rnd_d = rnd_q - 5'd1;
                    end
                end
            end
            default: begin
                dout_d  = data_q ^ rk;
                done_d  = 1'b1;
                state_d = S_IDLE;
`ifdef PRESENT_KEY_CACHE_EN
                if (!dec_q) begin
                    ck_fin_d = key_q;
                    ck_vld_d = 1'b1;
                end
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
            dec_q   <= 1'b0;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
            dec_q   <= dec_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef PRESENT_KEY_CACHE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ck_key_q <= '0;
            ck_fin_q <= '0;
            ck_vld_q <= 1'b0;
        end else begin
            ck_key_q <= ck_key_d;
            ck_fin_q <= ck_fin_d;
            ck_vld_q <= ck_vld_d;
        end
    end
`endif

    assign bus.dout = dout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_present_core.sv
// Scoreboard bench for present_core: 80- and 128-bit instances against a behavioural PRESENT model.
module tb_present_core;
    localparam int NR = 31;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    present_core_if #(.KEY_WIDTH(80))  bus80 ();
    present_core_if #(.KEY_WIDTH(128)) bus128 ();

    present_core #(.KEY_WIDTH(80),  .NUM_ROUNDS(NR)) dut80  (.clk(clk), .rst_n(rst_n), .bus(bus80.slave));
    present_core #(.KEY_WIDTH(128), .NUM_ROUNDS(NR)) dut128 (.clk(clk), .rst_n(rst_n), .bus(bus128.slave));

    typedef struct {
        logic [63:0] exp;
        int          lat;
        int          acc;
        string       tag;
    } exp_t;

    exp_t         q0[$];
    exp_t         q1[$];
    int           checks = 0;
    int           errors = 0;
    bit           cv[2];
    logic [127:0] ck[2];
    int           bc[2];
    bit           dprev[2];

    localparam logic [3:0] SB  [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    localparam logic [3:0] SBI [16] = '{4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
                                        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA};

    function automatic logic [63:0] m_sbox(input logic [63:0] x, input bit inv);
        logic [63:0] y;
        for (int n = 0; n < 16; n++) y[4*n +: 4] = inv ? SBI[x[4*n +: 4]] : SB[x[4*n +: 4]];
        return y;
    endfunction

    // Bit j of nibble-column (j/4), row (j%4) moves to row-major position.
    function automatic logic [63:0] m_perm(input logic [63:0] x, input bit inv);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) begin
            if (inv) y[j] = x[(j % 4) * 16 + j / 4];
            else     y[(j % 4) * 16 + j / 4] = x[j];
        end
        return y;
    endfunction

    function automatic logic [63:0] ref_model(input logic [63:0] din, input logic [127:0] key,
                                              input int kw, input bit dec);
        logic [63:0]  rk [1:32];
        logic [79:0]  k80;
        logic [127:0] k128;
        logic [63:0]  s;
        k80  = key[79:0];
        k128 = key;
        for (int i = 1; i <= NR + 1; i++) begin
            if (kw == 80) begin
                rk[i] = k80[79:16];
                k80 = (k80 << 61) | (k80 >> 19);
                k80[79:76] = SB[k80[79:76]];
                k80[19:15] = k80[19:15] ^ 5'(i);
            end else begin
                rk[i] = k128[127:64];
                k128 = (k128 << 61) | (k128 >> 67);
                k128[127:124] = SB[k128[127:124]];
                k128[123:120] = SB[k128[123:120]];
                k128[66:62] = k128[66:62] ^ 5'(i);
            end
        end
        if (!dec) begin
            s = din;
            for (int i = 1; i <= NR; i++) s = m_perm(m_sbox(s ^ rk[i], 1'b0), 1'b0);
            return s ^ rk[NR + 1];
        end
        s = din ^ rk[NR + 1];
        for (int i = NR; i >= 1; i--) s = m_sbox(m_perm(s, 1'b1), 1'b1) ^ rk[i];
        return s;
    endfunction

    task automatic chk64(input string tag, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", tag, act, req);
        end
    endtask

    task automatic chki(input string tag, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", tag, act, req);
        end
    endtask

    task automatic score(input int d, input logic [63:0] dout, input int busy_cnt);
        exp_t e;
        int   n;
        n = (d == 0) ? q0.size() : q1.size();
        checks++;
        if (n == 0) begin
            errors++;
            $display("FAIL dut%0d_unexpected_done actual=done dout=%h required=no_done", d, dout);
        end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            chk64(e.tag, dout, e.exp);
            chki({e.tag, "_latency"}, cyc - e.acc, e.lat);
            chki({e.tag, "_busy_cycles"}, busy_cnt, e.lat - 1);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            bc[0] = 0;  bc[1] = 0;
            dprev[0] = 1'b0;  dprev[1] = 1'b0;
        end else begin
            if (bus80.busy) bc[0]++;
            if (bus80.done) begin
                chki("dut0_done_width", int'(dprev[0]), 0);
                score(0, bus80.dout, bc[0]);
                bc[0] = 0;
            end
            dprev[0] = bus80.done;
            if (bus128.busy) bc[1]++;
            if (bus128.done) begin
                chki("dut1_done_width", int'(dprev[1]), 0);
                score(1, bus128.dout, bc[1]);
                bc[1] = 0;
            end
            dprev[1] = bus128.done;
        end
    end

    task automatic drive(input int d, input bit s, input bit dec, input logic [63:0] din,
                         input logic [127:0] key);
        if (d == 0) begin
            bus80.start = s;  bus80.decrypt = dec;  bus80.din = din;  bus80.key = key[79:0];
        end else begin
            bus128.start = s; bus128.decrypt = dec; bus128.din = din; bus128.key = key;
        end
    endtask

    function automatic logic [127:0] rnd_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [63:0] rnd_din();
        return {$urandom, $urandom};
    endfunction

    task automatic run_op(input int d, input bit dec, input logic [63:0] din, input logic [127:0] key_in,
                          input logic [63:0] exp, input string tag, input bit poke);
        exp_t         e;
        int           lat;
        logic [127:0] key;
        bit           seen;
        key = key_in;
        if (d == 0) key[127:80] = '0;
        lat = NR + 1;
        if (dec) begin
`ifdef PRESENT_KEY_CACHE_EN
            if (!(cv[d] && ck[d] == key)) begin
                lat   = 2 * NR + 1;
                cv[d] = 1'b1;
                ck[d] = key;
            end
`else
            lat = 2 * NR + 1;
`endif
        end else begin
            cv[d] = 1'b1;
            ck[d] = key;
        end
        @(negedge clk);
        drive(d, 1'b1, dec, din, key);
        e.exp = exp;  e.lat = lat;  e.acc = cyc + 1;  e.tag = tag;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(negedge clk);
        drive(d, 1'b0, 1'($urandom), rnd_din(), rnd_key());
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (poke && n == 5)      drive(d, 1'b1, 1'($urandom), rnd_din(), rnd_key());
            else if (poke && n == 6) drive(d, 1'b0, 1'($urandom), rnd_din(), rnd_key());
            seen = (d == 0) ? bus80.done : bus128.done;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done_within_200", tag);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=still_running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] last_key[2];
        logic [127:0] k;
        logic [63:0]  din;
        bit           dec;
        int           d;

        cv[0] = 1'b0;  cv[1] = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk64("rst_dout80",  bus80.dout, 64'h0);
        chki ("rst_busy80",  int'(bus80.busy), 0);
        chki ("rst_done80",  int'(bus80.done), 0);
        chk64("rst_dout128", bus128.dout, 64'h0);
        chki ("rst_busy128", int'(bus128.busy), 0);
        chki ("rst_done128", int'(bus128.done), 0);
        rst_n = 1'b1;

        run_op(0, 1'b0, 64'h0, 128'h0, 64'h5579C1387B228445, "enc80_k0", 1'b0);
        run_op(0, 1'b0, 64'h0, {48'h0, {80{1'b1}}}, 64'hE72C46C0F5945049, "enc80_k1", 1'b1);
        run_op(0, 1'b1, 64'hA112FFC72F68417B, 128'h0, 64'hFFFFFFFFFFFFFFFF, "dec80_k0", 1'b0);
        run_op(1, 1'b0, 64'h0, 128'h0, 64'h96DB702A2E6900AF, "enc128_k0", 1'b0);
        run_op(1, 1'b1, 64'h96DB702A2E6900AF, 128'h0, 64'h0, "dec128_k0", 1'b1);

        // Abort an encrypt around round 10 after a start pulse that must be ignored.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 64'h0, 128'h0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, rnd_din(), rnd_key());
        repeat (3) @(negedge clk);
        drive(0, 1'b1, 1'b1, rnd_din(), rnd_key());
        @(negedge clk);
        drive(0, 1'b0, 1'b0, rnd_din(), rnd_key());
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        cv[0] = 1'b0;  cv[1] = 1'b0;
        @(negedge clk);
        chk64("abort_dout80", bus80.dout, 64'h0);
        chki ("abort_busy80", int'(bus80.busy), 0);
        chki ("abort_done80", int'(bus80.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 1'b0, 64'h0, 128'h0, 64'h5579C1387B228445, "post_rst_enc80", 1'b0);

        last_key[0] = 128'h0;
        last_key[1] = 128'h0;
        for (int t = 0; t < 24; t++) begin
            d   = t % 2;
            dec = 1'($urandom);
            din = rnd_din();
            k   = ($urandom % 3 == 0) ? last_key[d] : rnd_key();
            if (d == 0) k[127:80] = '0;
            last_key[d] = k;
            run_op(d, dec, din, k, ref_model(din, k, (d == 0) ? 80 : 128, dec),
                   $sformatf("rand%0d_dut%0d_%s", t, d, dec ? "dec" : "enc"), ($urandom % 4) == 0);
        end

        repeat (5) @(negedge clk);
        chki("scoreboard_empty80",  q0.size(), 0);
        chki("scoreboard_empty128", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
